// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
// At most one request is outstanding; the address is held until the response arrives.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// RV32I fetch stage with IF/ID register. Memory wait states and killed or stalled
// responses become bubbles into decode; a one-entry skid buffer holds a word that arrives under StallF.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          StallF,
  input  logic          StallD,
  input  logic          FlushD,
  input  logic          PCSrcE,
  input  logic [31:0]   PCTargetE,
  fetch_stage_if.master imem,
  output logic [31:0]   InstrD,
  output logic [31:0]   PCD,
  output logic [31:0]   PCPlus4D,
  output logic          ValidD
);

  typedef enum logic [1:0] {FETCH, KILL, HOLD} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        valid;
  } ifid_t;

  state_t      state, stateNxt;
  logic [31:0] pcF, pcFNxt, reqPc, reqPcNxt, skid, skidNxt;
  logic [31:0] target, pcPlus4F, dInstr;
  logic        deliver;
  ifid_t       ifid, ifidNxt;
  logic        unusedBits;

  assign target     = {PCTargetE[31:2], 2'b00};
  assign unusedBits = ^PCTargetE[1:0];
  assign pcPlus4F   = pcF + 32'd4;

  assign imem.imem_req  = rst_n & (state != HOLD);
  assign imem.imem_addr = reqPc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      pcF   <= RESET_PC;
      reqPc <= RESET_PC;
      skid  <= NOP_INSTR;
      ifid  <= '{instr: NOP_INSTR, pc: 32'd0, pcPlus4: 32'd0, valid: 1'b0};
    end else begin
      state <= stateNxt;
      pcF   <= pcFNxt;
      reqPc <= reqPcNxt;
      skid  <= skidNxt;
      ifid  <= ifidNxt;
    end
  end

  // Redirect beats stall everywhere; delivered word's PC is always pcF.
  always_comb begin
    stateNxt = state;
    pcFNxt   = pcF;
    reqPcNxt = reqPc;
    skidNxt  = skid;
    deliver  = 1'b0;
    dInstr   = imem.imem_rdata;
    case (state)
      FETCH: begin
        if (imem.imem_rvalid) begin
          if (PCSrcE) begin
            pcFNxt   = target;
            reqPcNxt = target;
          end else if (!StallF) begin
            deliver  = 1'b1;
            pcFNxt   = pcPlus4F;
            reqPcNxt = pcPlus4F;
          end else begin
            skidNxt  = imem.imem_rdata;
            stateNxt = HOLD;
          end
        end else if (PCSrcE) begin
          pcFNxt   = target;
          stateNxt = KILL;
        end
      end
      KILL: begin
        if (PCSrcE) pcFNxt = target;
        if (imem.imem_rvalid) begin
          reqPcNxt = PCSrcE ? target : pcF;
          stateNxt = FETCH;
        end
      end
      HOLD: begin
        if (PCSrcE) begin
          pcFNxt   = target;
          reqPcNxt = target;
          stateNxt = FETCH;
        end else if (!StallF) begin
          deliver  = 1'b1;
          dInstr   = skid;
          pcFNxt   = pcPlus4F;
          reqPcNxt = pcPlus4F;
          stateNxt = FETCH;
        end
      end
      default: stateNxt = FETCH;
    endcase
  end

  always_comb begin
    ifidNxt = ifid;
    if (FlushD) begin
      ifidNxt.instr = NOP_INSTR;
      ifidNxt.valid = 1'b0;
    end else if (StallD) begin
      ifidNxt = ifid;
    end else if (deliver) begin
      ifidNxt = '{instr: dInstr, pc: pcF, pcPlus4: pcPlus4F, valid: 1'b1};
    end else begin
      ifidNxt.instr = NOP_INSTR;
      ifidNxt.valid = 1'b0;
    end
  end

  assign InstrD   = ifid.instr;
  assign PCD      = ifid.pc;
  assign PCPlus4D = ifid.pcPlus4;
  assign ValidD   = ifid.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed cycle table, reset pulse, then random stalls,
// redirects and memory latency checked against an instruction-stream model.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        StallF = 0, StallD = 0, FlushD = 0, PCSrcE = 0;
  logic [31:0] PCTargetE = 0;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;
  int unsigned lat = 0, waitCnt;
  int          nChk = 0, nPass = 0;

  always #5 clk = ~clk;

  fetch_stage_if imem ();

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem(imem),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory: answers after 'lat' wait cycles; reset abandons the pending request.
  assign imem.imem_rvalid = imem.imem_req && (waitCnt >= lat);
  assign imem.imem_rdata  = imem.imem_rvalid ? memWord(imem.imem_addr) : 32'hDEAD_BEEF;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) waitCnt <= 0;
    else if (imem.imem_req && !imem.imem_rvalid) waitCnt <= waitCnt + 1;
    else waitCnt <= 0;

  logic        hsWait;
  logic [31:0] prevAddr;
  always @(posedge clk) begin
    hsWait   <= imem.imem_req && !imem.imem_rvalid;
    prevAddr <= imem.imem_addr;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  typedef struct {
    logic sF, sD, fD, pc;
    logic [31:0] tgt;
    int unsigned lat;
    logic eReq;
    logic [31:0] eAddr;
    logic eValid;
    logic [31:0] ePcd;
  } vec_t;

  function automatic vec_t mk(input logic sF, sD, fD, pc, input logic [31:0] tgt,
                              input int unsigned l, input logic eReq, input logic [31:0] eAddr,
                              input logic eValid, input logic [31:0] ePcd);
    vec_t v;
    v.sF = sF; v.sD = sD; v.fD = fD; v.pc = pc; v.tgt = tgt; v.lat = l;
    v.eReq = eReq; v.eAddr = eAddr; v.eValid = eValid; v.ePcd = ePcd;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[26];
    logic [31:0] expPc, hInstr, hPcd;
    logic        hValid;
    int          nDeliv = 0;

    tbl[0]  = mk(0,0,0,0, 0,            0, 1, 32'h4,        1, 32'h0);
    tbl[1]  = mk(0,0,0,0, 0,            0, 1, 32'h8,        1, 32'h4);
    tbl[2]  = mk(1,1,0,0, 0,            0, 0, 32'h8,        1, 32'h4);
    tbl[3]  = mk(1,1,0,0, 0,            0, 0, 32'h8,        1, 32'h4);
    tbl[4]  = mk(1,1,0,0, 0,            0, 0, 32'h8,        1, 32'h4);
    tbl[5]  = mk(0,0,0,0, 0,            0, 1, 32'hC,        1, 32'h8);
    tbl[6]  = mk(0,0,0,0, 0,            0, 1, 32'h10,       1, 32'hC);
    tbl[7]  = mk(0,0,0,0, 0,            2, 1, 32'h10,       0, 32'h0);
    tbl[8]  = mk(0,0,1,1, 32'h100,      2, 1, 32'h10,       0, 32'h0);
    tbl[9]  = mk(0,0,0,0, 0,            2, 1, 32'h100,      0, 32'h0);
    tbl[10] = mk(0,0,0,0, 0,            0, 1, 32'h104,      1, 32'h100);
    tbl[11] = mk(1,1,1,1, 32'h203,      0, 1, 32'h200,      0, 32'h0);
    tbl[12] = mk(0,0,0,0, 0,            0, 1, 32'h204,      1, 32'h200);
    tbl[13] = mk(0,0,1,1, 32'hFFFF_FFFF,0, 1, 32'hFFFF_FFFC,0, 32'h0);
    tbl[14] = mk(0,0,0,0, 0,            0, 1, 32'h0,        1, 32'hFFFF_FFFC);
    tbl[15] = mk(0,0,0,0, 0,            0, 1, 32'h4,        1, 32'h0);
    tbl[16] = mk(0,0,1,0, 0,            0, 1, 32'h8,        0, 32'h0);
    tbl[17] = mk(0,0,0,0, 0,            0, 1, 32'hC,        1, 32'h8);
    tbl[18] = mk(1,1,0,0, 0,            0, 0, 32'hC,        1, 32'h8);
    tbl[19] = mk(1,1,1,1, 32'h40,       0, 1, 32'h40,       0, 32'h0);
    tbl[20] = mk(0,0,0,0, 0,            0, 1, 32'h44,       1, 32'h40);
    tbl[21] = mk(0,0,0,0, 0,            1, 1, 32'h44,       0, 32'h0);
    tbl[22] = mk(0,0,1,1, 32'h80,       3, 1, 32'h44,       0, 32'h0);
    tbl[23] = mk(0,0,1,1, 32'h92,       3, 1, 32'h44,       0, 32'h0);
    tbl[24] = mk(0,0,0,0, 0,            3, 1, 32'h90,       0, 32'h0);
    tbl[25] = mk(0,0,0,0, 0,            0, 1, 32'h94,       1, 32'h90);

    // Reset values
    #12;
    chk("rst_req", {31'd0, imem.imem_req}, 32'd0);
    chk("rst_valid", {31'd0, ValidD}, 32'd0);
    chk("rst_instr", InstrD, NOP);
    chk("rst_pcd", PCD, 32'd0);
    chk("rst_pcp4", PCPlus4D, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    foreach (tbl[i]) begin
      StallF = tbl[i].sF; StallD = tbl[i].sD; FlushD = tbl[i].fD;
      PCSrcE = tbl[i].pc; PCTargetE = tbl[i].tgt; lat = tbl[i].lat;
      @(posedge clk); @(negedge clk);
      chk($sformatf("row%0d_req", i), {31'd0, imem.imem_req}, {31'd0, tbl[i].eReq});
      chk($sformatf("row%0d_addr", i), imem.imem_addr, tbl[i].eAddr);
      chk($sformatf("row%0d_valid", i), {31'd0, ValidD}, {31'd0, tbl[i].eValid});
      if (tbl[i].eValid) begin
        chk($sformatf("row%0d_pcd", i), PCD, tbl[i].ePcd);
        chk($sformatf("row%0d_instr", i), InstrD, memWord(tbl[i].ePcd));
        chk($sformatf("row%0d_pcp4", i), PCPlus4D, tbl[i].ePcd + 32'd4);
      end else begin
        chk($sformatf("row%0d_nop", i), InstrD, NOP);
      end
    end
    StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 0;

    // Reset pulse while a request is waiting
    lat = 3;
    @(posedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", {31'd0, imem.imem_req}, 32'd0);
    chk("arst_valid", {31'd0, ValidD}, 32'd0);
    chk("arst_instr", InstrD, NOP);
    chk("arst_pcd", PCD, 32'd0);
    chk("arst_pcp4", PCPlus4D, 32'd0);
    @(negedge clk) begin rst_n = 1'b1; lat = 0; end
    chk("restart_addr", imem.imem_addr, 32'h0);
    @(posedge clk); @(negedge clk);
    chk("restart_valid", {31'd0, ValidD}, 32'd1);
    chk("restart_pcd", PCD, 32'h0);

    // Random phase: delivered stream must be sequential words, restarting at each redirect target
    expPc = 32'h4;
    hInstr = InstrD; hPcd = PCD; hValid = ValidD;
    for (int c = 0; c < 3000; c++) begin
      if (waitCnt == 0) lat = $urandom_range(0, 3);
      StallF    = ($urandom % 5) == 0;
      StallD    = StallF;
      PCSrcE    = ($urandom % 12) == 0;
      FlushD    = PCSrcE;
      PCTargetE = $urandom;
      @(posedge clk); @(negedge clk);
      if (FlushD) begin
        chk("rnd_flush_valid", {31'd0, ValidD}, 32'd0);
        chk("rnd_flush_instr", InstrD, NOP);
      end else if (StallD) begin
        chk("rnd_hold_instr", InstrD, hInstr);
        chk("rnd_hold_pcd", PCD, hPcd);
        chk("rnd_hold_valid", {31'd0, ValidD}, {31'd0, hValid});
      end else if (ValidD) begin
        chk("rnd_pcd", PCD, expPc);
        chk("rnd_instr", InstrD, memWord(expPc));
        chk("rnd_pcp4", PCPlus4D, expPc + 32'd4);
        expPc = expPc + 32'd4;
        nDeliv++;
      end else begin
        chk("rnd_bubble", InstrD, NOP);
      end
      if (PCSrcE) expPc = {PCTargetE[31:2], 2'b00};
      if (hsWait && imem.imem_req) chk("rnd_addr_stable", imem.imem_addr, prevAddr);
      chk("rnd_addr_align", {30'd0, imem.imem_addr[1:0]}, 32'd0);
      hInstr = InstrD; hPcd = PCD; hValid = ValidD;
    end
    chk("rnd_progress", {31'd0, nDeliv >= 200}, 32'd1);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end
endmodule
